key_sel_ctrl: RTL and testbench
===============================

Name: key_sel_ctrl

Overview:
- Upstream control stage for the 2:1 mux (II_mux_2_1); this block produces the mux's sel_0 input.
- Converts a raw, bouncing push-button into:
  - a debounced key level;
  - a one-cycle press pulse;
  - a registered select bit that toggles on every accepted press.
- sel_0 connects directly to the mux's sel_0 port, so a button press swaps the routed input between in_0 and in_1.

Parameters:
- CNT_MAX, 999_999: debounce terminal count (20 ms at 50 MHz). Counter width is $clog2(CNT_MAX+1).
- KEY_ACTIVE, 1'b0: key_in level that means "pressed". Default is an active-low button.
- LONG_MAX, 49_999_999: long-press terminal count (1 s at 50 MHz). Used only with LONG_PRESS_EN.

Ports:
- sys_clk, input, 1: system clock. All logic is on the rising edge.
- sys_rst, input, 1: asynchronous, active-high reset.
- key_in, input, 1: raw asynchronous button level.
- key_state, output, 1: debounced level. 1 = pressed.
- key_flag, output, 1: one-cycle pulse on each accepted press.
- sel_0, output, 1: toggle register that drives the mux sel_0.
- long_flag, output, 1: one-cycle long-press pulse. Present only with LONG_PRESS_EN.

Behaviour:
- Reset (asynchronous, sys_rst=1):
  - Both synchronizer FFs load the inactive level (~KEY_ACTIVE).
  - state=IDLE, cnt=0.
  - key_state=0, key_flag=0, sel_0=0, long_flag=0.
  - Reset asserted mid-filter or mid-hold abandons the press; no pulse is emitted.
  - A key still held after reset release must pass the full filter again.
- Synchronizer:
  - 2-FF chain on key_in. key_act = (sync2 == KEY_ACTIVE).
  - The FSM uses only key_act, never key_in.
- FSM states: IDLE, FILT_DN, DOWN, FILT_UP. All outputs are registered.
- IDLE:
  - key_act=1 -> FILT_DN, cnt=0.
- FILT_DN:
  - key_act=0 -> IDLE, cnt=0 (bounce rejected).
  - else if cnt==CNT_MAX -> DOWN; key_state<=1, key_flag<=1, sel_0<=~sel_0.
  - else cnt<=cnt+1.
- DOWN:
  - key_act=0 -> FILT_UP, cnt=0.
- FILT_UP:
  - key_act=1 -> DOWN, cnt=0 (release bounce). No new key_flag.
  - else if cnt==CNT_MAX -> IDLE, key_state<=0.
  - else cnt<=cnt+1.
- key_flag:
  - High for exactly one cycle per accepted press. It is cleared on the next edge.
  - Releases never generate a pulse.
- Latency, counting the edge that first samples the new key_in as edge 1:
  - sync2 valid at edge 2; FILT_DN at edge 3.
  - key_flag, key_state and sel_0 change at edge CNT_MAX+4.
  - Release: key_state falls at edge CNT_MAX+4 after key_in goes inactive.
- Any glitch shorter than CNT_MAX+1 consecutive synced cycles is rejected completely.
- cnt saturates by design (transition at CNT_MAX), so it never wraps.
- sel_0 toggles only on the FILT_DN->DOWN transition. It holds its value indefinitely otherwise.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Adds a second counter lcnt (width $clog2(LONG_MAX+1)), cleared on entry to DOWN.
  - lcnt increments in DOWN and FILT_UP, and saturates at LONG_MAX.
  - When lcnt reaches LONG_MAX: long_flag pulses one cycle and sel_0 is forced to 0 (mux returns to in_0).
  - Only one long_flag per hold.
  - lcnt clears on return to IDLE.
- Undefined:
  - No long_flag port, no lcnt logic.
  - Behaviour is otherwise identical.

Test Plan (CNT_MAX=4, LONG_MAX=20, KEY_ACTIVE=0, 20 ns clock):
1. Reset: hold sys_rst=1 with key_in=0 -> key_state=0, key_flag=0, sel_0=0 throughout. After release, the held key needs the full 8 edges before key_flag pulses.
2. Clean press: key_in 1->0 and held -> key_flag=1 for one cycle at edge 8, key_state=1, sel_0=1. Release -> key_state=0 at edge 8 after release, sel_0 stays 1, no pulse. Second press -> sel_0=0.
3. Bounce: key_in=0 for 3 cycles, then 1 for 1 cycle, repeated 5 times, then stable 0 -> exactly one key_flag, 8 edges after the last stable edge; sel_0 toggles once.
4. Release bounce: while DOWN, key_in=1 for 2 cycles then back to 0 -> key_state stays 1, no key_flag, sel_0 unchanged.
5. Reset mid-operation: assert sys_rst during FILT_DN (cnt=2) and separately during DOWN -> immediate key_state=0, sel_0=0, key_flag=0. No pulse after reset release unless a full filter completes.
6. LONG_PRESS_EN defined: press and hold 40 cycles -> key_flag at edge 8 (sel_0=1), then long_flag one cycle 21 edges after DOWN entry, with sel_0 forced to 0. A single long_flag only, even with continued hold.

Source files
------------

// File: rtl/key_sel_ctrl.sv
// ============================================================================
// Module   : key_sel_ctrl
// Brief    : Push-button debouncer producing a debounced level, a press pulse
//            and a toggling select bit that drives the 2:1 mux sel_0 input.
//            Optional long-press detection is built when LONG_PRESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sel_ctrl #(
    parameter int unsigned CNT_MAX    = 999_999,
    parameter logic        KEY_ACTIVE = 1'b0,
    parameter int unsigned LONG_MAX   = 49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_state,
    output logic key_flag,
    output logic sel_0
`ifdef LONG_PRESS_EN
    ,
    output logic long_flag
`endif
);

    localparam int                 CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   C_CNT_MAX = CNT_W'(CNT_MAX);

    // A zero terminal count would collapse the counter to zero width.
    if (CNT_MAX == 0 || LONG_MAX == 0) begin : g_param_chk
        $error("key_sel_ctrl: CNT_MAX and LONG_MAX must be nonzero");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILT_DN = 2'd1,
        S_DOWN    = 2'd2,
        S_FILT_UP = 2'd3
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             w_key_act;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             key_state_q, key_state_d;
    logic             key_flag_q,  key_flag_d;
    logic             sel_q,       sel_d;

`ifdef LONG_PRESS_EN
    localparam int                LCNT_W     = $clog2(LONG_MAX + 1);
    localparam logic [LCNT_W-1:0] C_LONG_MAX = LCNT_W'(LONG_MAX);

    logic [LCNT_W-1:0] lcnt_q,      lcnt_d;
    logic              long_flag_q, long_flag_d;
    logic              long_done_q, long_done_d;
`endif

    assign w_key_act = (sync2_q == KEY_ACTIVE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q     <= ~KEY_ACTIVE;
            sync2_q     <= ~KEY_ACTIVE;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            key_flag_q  <= 1'b0;
            sel_q       <= 1'b0;
`ifdef LONG_PRESS_EN
            lcnt_q      <= '0;
            long_flag_q <= 1'b0;
            long_done_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            key_flag_q  <= key_flag_d;
            sel_q       <= sel_d;
`ifdef LONG_PRESS_EN
            lcnt_q      <= lcnt_d;
            long_flag_q <= long_flag_d;
            long_done_q <= long_done_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        key_flag_d  = 1'b0;
        sel_d       = sel_q;

        case (state_q)
            S_IDLE: begin
                if (w_key_act) begin
                    state_d = S_FILT_DN;
                    cnt_d   = '0;
                end
            end
            S_FILT_DN: begin
                if (!w_key_act) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d     = S_DOWN;
                    key_state_d = 1'b1;
                    key_flag_d  = 1'b1;
                    sel_d       = ~sel_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DOWN: begin
                if (!w_key_act) begin
                    state_d = S_FILT_UP;
                    cnt_d   = '0;
                end
            end
            S_FILT_UP: begin
                if (w_key_act) begin
                    state_d = S_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d     = S_IDLE;
                    key_state_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef LONG_PRESS_EN
        lcnt_d      = lcnt_q;
        long_flag_d = 1'b0;
        long_done_d = long_done_q;

        // Hold time keeps accumulating through release bounce; one pulse per hold.
        if (state_q == S_DOWN || state_q == S_FILT_UP) begin
            if (lcnt_q == C_LONG_MAX) begin
                if (!long_done_q) begin
                    long_flag_d = 1'b1;
                    long_done_d = 1'b1;
                    sel_d       = 1'b0;
                end
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end

        if (state_d == S_IDLE || (state_q == S_FILT_DN && state_d == S_DOWN)) begin
            lcnt_d      = '0;
            long_done_d = 1'b0;
        end
`endif
    end

    assign key_state = key_state_q;
    assign key_flag  = key_flag_q;
    assign sel_0     = sel_q;
`ifdef LONG_PRESS_EN
    assign long_flag = long_flag_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_sel_ctrl.sv
// ============================================================================
// Module   : tb_key_sel_ctrl
// Brief    : Directed self-checking bench for key_sel_ctrl (CNT_MAX=4, LONG_MAX=20).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_sel_ctrl;

    logic sys_clk;
    logic sys_rst;
    logic key_in;
    logic key_state;
    logic key_flag;
    logic sel_0;
`ifdef LONG_PRESS_EN
    logic long_flag;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_kf    = 0;
    int n_ks_lo = 0;
    int n_lf    = 0;
    int base;

    key_sel_ctrl #(
        .CNT_MAX    (4),
        .KEY_ACTIVE (1'b0),
        .LONG_MAX   (20)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_in    (key_in),
        .key_state (key_state),
        .key_flag  (key_flag),
        .sel_0     (sel_0)
`ifdef LONG_PRESS_EN
        ,
        .long_flag (long_flag)
`endif
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later; running counts of pulses seen.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (key_flag)   n_kf++;
        if (!key_state) n_ks_lo++;
`ifdef LONG_PRESS_EN
        if (long_flag)  n_lf++;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        sys_rst = 1'b1;
        key_in  = 1'b0;

        // 1: reset held with key pressed
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_key_state", key_state, 0);
            check("rst_key_flag",  key_flag,  0);
            check("rst_sel",       sel_0,     0);
        end
        sys_rst = 1'b0;
        base = n_kf;
        ticks(7);
        check("rst_rel_no_early_flag", n_kf - base, 0);
        check("rst_rel_state_e7",      key_state,   0);
        tick();
        check("press1_flag_e8",  key_flag,  1);
        check("press1_state_e8", key_state, 1);
        check("press1_sel_e8",   sel_0,     1);
        tick();
        check("press1_flag_once", key_flag, 0);

        // 2: clean release then second press
        key_in = 1'b1;
        base = n_kf;
        ticks(7);
        check("rel_state_e7", key_state, 1);
        tick();
        check("rel_state_e8",  key_state,   0);
        check("rel_sel_hold",  sel_0,       1);
        check("rel_no_flag",   n_kf - base, 0);
        key_in = 1'b0;
        ticks(7);
        check("press2_flag_e7", key_flag, 0);
        tick();
        check("press2_flag_e8", key_flag, 1);
        check("press2_sel",     sel_0,    0);
        tick();
        key_in = 1'b1;
        ticks(10);
        check("press2_released", key_state, 0);

        // 3: press bounce, five short lows then stable
        base = n_kf;
        for (int r = 0; r < 5; r++) begin
            key_in = 1'b0;
            ticks(3);
            key_in = 1'b1;
            tick();
        end
        key_in = 1'b0;
        ticks(7);
        check("bounce_rejected", n_kf - base, 0);
        check("bounce_state_lo", key_state,   0);
        tick();
        check("bounce_flag_e8", key_flag, 1);
        check("bounce_sel",     sel_0,    1);
        ticks(2);
        check("bounce_one_flag", n_kf - base, 1);

        // 4: release bounce while DOWN
        base = n_kf;
        n_ks_lo = 0;
        key_in = 1'b1;
        ticks(2);
        key_in = 1'b0;
        ticks(6);
        check("relb_state_never_lo", n_ks_lo,     0);
        check("relb_no_flag",        n_kf - base, 0);
        check("relb_sel",            sel_0,       1);
        key_in = 1'b1;
        ticks(10);
        check("relb_released", key_state, 0);

        // 5a: reset during FILT_DN with cnt=2, key kept held
        key_in = 1'b0;
        ticks(5);
        sys_rst = 1'b1;
        #1;
        check("rstfd_sel_async",   sel_0,     0);
        check("rstfd_state_async", key_state, 0);
        ticks(2);
        sys_rst = 1'b0;
        base = n_kf;
        ticks(7);
        check("rstfd_no_early_flag", n_kf - base, 0);
        tick();
        check("rstfd_flag_e8", key_flag, 1);
        check("rstfd_sel_e8",  sel_0,    1);

        // 5b: reset during DOWN, then key released
        ticks(2);
        sys_rst = 1'b1;
        #1;
        check("rstdn_state_async", key_state, 0);
        check("rstdn_sel_async",   sel_0,     0);
        check("rstdn_flag_async",  key_flag,  0);
        key_in = 1'b1;
        tick();
        sys_rst = 1'b0;
        base = n_kf;
        ticks(12);
        check("rstdn_no_flag", n_kf - base, 0);
        check("rstdn_state",   key_state,   0);
        check("rstdn_sel",     sel_0,       0);

`ifdef LONG_PRESS_EN
        // 6: long press
        key_in = 1'b0;
        ticks(8);
        check("long_kflag_e8", key_flag, 1);
        check("long_sel_e8",   sel_0,    1);
        base = n_lf;
        ticks(20);
        check("long_no_early", n_lf - base, 0);
        check("long_sel_hold", sel_0,       1);
        tick();
        check("long_flag_e29", long_flag, 1);
        check("long_sel_forced", sel_0,   0);
        ticks(15);
        check("long_single", n_lf - base, 1);
        check("long_sel_stays", sel_0,    0);
        key_in = 1'b1;
        ticks(10);
        check("long_released", key_state, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
